// File: rtl/music_seq_ctrl.sv
// music_seq_ctrl: request-driven song sequencer in front of the tone generator.
// Plays one of two song ROMs one note per slot, with stop, loop and a short
// beep that pre-empts a song and then replays the interrupted note.
// Every note is shown for a full slot. The displayed note changes two cycles
// into its slot because of the fetch/load latency. The end of a song or of a
// stand-alone beep is therefore also delayed two cycles ("drain"), so that the
// last note keeps its full length.
module music_seq_ctrl #(
  parameter int CLK_HZ     = 25000000,
  parameter int TICK_HZ    = 16,
  parameter int SONG0_LEN  = 516,
  parameter int SONG1_LEN  = 320,
  parameter int ADDR_W     = 10,
  parameter int NOTE_W     = 6,
  parameter int SILENCE    = 21,
  parameter int BEEP_NOTE  = 14,
  parameter int BEEP_SLOTS = 2
) (
  input  logic              IN_clk,
  input  logic              IN_rst,
  input  logic [1:0]        IN_play,
  input  logic              IN_beep,
  input  logic              IN_stop,
  input  logic              IN_loop,
  output logic              OUT_rom_sel,
  output logic [ADDR_W-1:0] OUT_rom_addr,
  input  logic [NOTE_W-1:0] IN_rom_data,
  output logic [NOTE_W-1:0] OUT_note,
  output logic              OUT_busy,
  output logic              OUT_done
);

  localparam int SLOT   = CLK_HZ / TICK_HZ;
  localparam int SLOT_W = (SLOT > 1) ? $clog2(SLOT) : 1;
  localparam int BCNT_W = (BEEP_SLOTS > 1) ? $clog2(BEEP_SLOTS) : 1;

  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SLOT - 1);
  localparam logic [SLOT_W-1:0] SLOT_ONE  = SLOT_W'(1);
  localparam logic [BCNT_W-1:0] BEEP_LAST = BCNT_W'(BEEP_SLOTS - 1);
  localparam logic [ADDR_W-1:0] LAST0     = ADDR_W'(SONG0_LEN - 1);
  localparam logic [ADDR_W-1:0] LAST1     = ADDR_W'(SONG1_LEN - 1);
  localparam logic [NOTE_W-1:0] NOTE_SIL  = NOTE_W'(SILENCE);
  localparam logic [NOTE_W-1:0] NOTE_BEEP = NOTE_W'(BEEP_NOTE);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_LOAD, S_HOLD, S_BEEP} state_t;

  state_t              state_q, state_d;
  logic [SLOT_W-1:0]   slot_q, slot_d;
  logic [BCNT_W-1:0]   bcnt_q, bcnt_d;
  logic                sel_q, sel_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [NOTE_W-1:0]   note_q, note_d;
  logic                done_q, done_d;
  logic                saved_q, saved_d;   // sel_q/addr_q hold a song to resume after the beep
  logic                drain_q, drain_d;   // last slot finished, waiting out the 2-cycle tail

  logic                slot_end;
  logic                song_act;
  logic [ADDR_W-1:0]   last_addr;

  assign slot_end  = (slot_q == SLOT_LAST);
  assign song_act  = (state_q == S_FETCH) || (state_q == S_LOAD) || (state_q == S_HOLD);
  assign last_addr = sel_q ? LAST1 : LAST0;

  // State and datapath registers; reset returns everything to idle silence.
  always_ff @(posedge IN_clk) begin
    if (IN_rst) begin
      state_q <= S_IDLE;
      slot_q  <= '0;
      bcnt_q  <= '0;
      sel_q   <= 1'b0;
      addr_q  <= '0;
      note_q  <= NOTE_SIL;
      done_q  <= 1'b0;
      saved_q <= 1'b0;
      drain_q <= 1'b0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      bcnt_q  <= bcnt_d;
      sel_q   <= sel_d;
      addr_q  <= addr_d;
      note_q  <= note_d;
      done_q  <= done_d;
      saved_q <= saved_d;
      drain_q <= drain_d;
    end
  end

  // Next-state logic: requests in priority order stop > beep > play, then sequencing.
  always_comb begin
    state_d = state_q;
    slot_d  = slot_end ? '0 : slot_q + SLOT_ONE;
    bcnt_d  = bcnt_q;
    sel_d   = sel_q;
    addr_d  = addr_q;
    note_d  = note_q;
    done_d  = 1'b0;
    saved_d = saved_q;
    drain_d = drain_q;

    if (IN_stop && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      note_d  = NOTE_SIL;
      addr_d  = '0;
      saved_d = 1'b0;
      drain_d = 1'b0;
      done_d  = song_act | saved_q;
    end else if (IN_beep) begin
      state_d = S_BEEP;
      slot_d  = '0;
      bcnt_d  = '0;
      drain_d = 1'b0;
      // A song already draining its final note has nothing left to resume.
      if (song_act) saved_d = ~drain_q;
    end else if (|IN_play) begin
      sel_d  = IN_play[1];
      addr_d = '0;
      if (state_q == S_BEEP) begin
        saved_d = 1'b1;
      end else begin
        state_d = S_FETCH;
        slot_d  = '0;
        drain_d = 1'b0;
      end
    end else begin
      case (state_q)
        S_IDLE: ;
        S_FETCH: state_d = S_LOAD;
        S_LOAD: begin
          note_d  = IN_rom_data;
          state_d = S_HOLD;
        end
        S_HOLD: begin
          if (drain_q) begin
            if (slot_q == SLOT_ONE) begin
              state_d = S_IDLE;
              note_d  = NOTE_SIL;
              addr_d  = '0;
              done_d  = 1'b1;
              drain_d = 1'b0;
            end
          end else if (slot_end) begin
            if (addr_q == last_addr) begin
              if (IN_loop) begin
                addr_d  = '0;
                state_d = S_FETCH;
              end else begin
                drain_d = 1'b1;
              end
            end else begin
              addr_d  = addr_q + ADDR_W'(1);
              state_d = S_FETCH;
            end
          end
        end
        S_BEEP: begin
          // Beep tone appears at the same point in the slot as a fetched note.
          if ((bcnt_q == '0) && (slot_q == SLOT_ONE) && !drain_q) note_d = NOTE_BEEP;
          if (drain_q) begin
            if (slot_q == SLOT_ONE) begin
              drain_d = 1'b0;
              if (saved_q) begin
                state_d = S_FETCH;
                saved_d = 1'b0;
              end else begin
                state_d = S_IDLE;
                note_d  = NOTE_SIL;
              end
            end
          end else if (slot_end) begin
            if (bcnt_q == BEEP_LAST) begin
              if (saved_q) begin
                state_d = S_FETCH;
                saved_d = 1'b0;
              end else begin
                drain_d = 1'b1;
              end
            end else begin
              bcnt_d = bcnt_q + BCNT_W'(1);
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign OUT_rom_sel  = sel_q;
  assign OUT_rom_addr = addr_q;
  assign OUT_note     = note_q;
  assign OUT_busy     = (state_q != S_IDLE);
  assign OUT_done     = done_q;

endmodule

// File: tb/tb_music_seq_ctrl.sv
// Bench for music_seq_ctrl with SLOT=10, song0 {5,6,7,9}, song1 {40,41,42}.
// Segment table drives pulses and pushes expected per-cycle outputs; a
// checker pops them one cycle-edge later and compares.
module tb_music_seq_ctrl;

  localparam logic [5:0] SIL = 6'd21;
  localparam logic [5:0] BP  = 6'd14;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] play = 2'b00;
  logic       beep = 1'b0, stop = 1'b0, loop = 1'b0;
  logic       rom_sel;
  logic [9:0] rom_addr;
  logic [5:0] rom_data = 6'd0;
  logic [5:0] note;
  logic       busy, done;

  always #5 clk = ~clk;

  music_seq_ctrl #(
    .CLK_HZ(160), .TICK_HZ(16), .SONG0_LEN(4), .SONG1_LEN(3), .ADDR_W(10),
    .NOTE_W(6), .SILENCE(21), .BEEP_NOTE(14), .BEEP_SLOTS(2)
  ) dut (
    .IN_clk(clk), .IN_rst(rst), .IN_play(play), .IN_beep(beep), .IN_stop(stop),
    .IN_loop(loop), .OUT_rom_sel(rom_sel), .OUT_rom_addr(rom_addr),
    .IN_rom_data(rom_data), .OUT_note(note), .OUT_busy(busy), .OUT_done(done)
  );

  // Synchronous song ROMs: data one cycle after the address.
  logic [5:0] rom0 [4];
  logic [5:0] rom1 [4];
  initial begin
    rom0 = '{6'd5, 6'd6, 6'd7, 6'd9};
    rom1 = '{6'd40, 6'd41, 6'd42, 6'd63};
  end
  always @(posedge clk) begin
    if (rom_sel) rom_data <= (rom_addr < 10'd3) ? rom1[rom_addr[1:0]] : 6'd63;
    else         rom_data <= (rom_addr < 10'd4) ? rom0[rom_addr[1:0]] : 6'd63;
  end

  typedef struct {
    logic [5:0] note;
    logic       busy;
    logic       done;
    logic       sel;
    logic       chk_addr;
    int         id;
  } exp_t;

  typedef struct {
    logic       r;
    logic [1:0] p;
    logic       b;
    logic       s;
    logic       l;
    logic [5:0] note;
    logic       busy;
    logic       done;
    logic       sel;
    int         n;
  } seg_t;

  exp_t exp_q[$];
  seg_t tbl[$];
  int   total = 0;
  int   bad   = 0;
  int   step_id = 0;
  exp_t ce;

  task automatic chk(input string nm, input int id, input int act, input int want);
    total++;
    if (act != want) begin
      bad++;
      $display("FAIL %s step=%0d got=%0d want=%0d", nm, id, act, want);
    end
  endtask

  // Checker: compare the DUT against the oldest pending expectation.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      ce = exp_q.pop_front();
      chk("note", ce.id, int'(note), int'(ce.note));
      chk("busy", ce.id, int'(busy), int'(ce.busy));
      chk("done", ce.id, int'(done), int'(ce.done));
      if (!$isunknown(ce.sel)) chk("rom_sel", ce.id, int'(rom_sel), int'(ce.sel));
      if (ce.chk_addr) chk("rom_addr_reset", ce.id, int'(rom_addr), 0);
      chk("addr_in_range", ce.id, int'(rom_addr <= (rom_sel ? 10'd2 : 10'd3)), 1);
    end
  end

  task automatic apply(input logic r, input logic [1:0] p, input logic b, input logic s,
                       input logic l, input logic [5:0] en, input logic eb,
                       input logic ed, input logic es);
    exp_t e;
    @(negedge clk);
    rst = r; play = p; beep = b; stop = s; loop = l;
    e.note = en; e.busy = eb; e.done = ed; e.sel = es; e.chk_addr = r; e.id = step_id;
    step_id++;
    exp_q.push_back(e);
  endtask

  task automatic add(input logic r, input logic [1:0] p, input logic b, input logic s,
                     input logic l, input logic [5:0] en, input logic eb, input logic ed,
                     input logic es, input int n);
    tbl.push_back('{r, p, b, s, l, en, eb, ed, es, n});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // 1: song 0 once, no loop
    add(1,0,0,0,0, SIL,0,0,0, 2);
    add(0,1,0,0,0, SIL,1,0,0, 2);
    add(0,0,0,0,0, 6'd5,1,0,0,10); add(0,0,0,0,0, 6'd6,1,0,0,10);
    add(0,0,0,0,0, 6'd7,1,0,0,10); add(0,0,0,0,0, 6'd9,1,0,0,10);
    add(0,0,0,0,0, SIL,0,1,0, 1);  add(0,0,0,0,0, SIL,0,0,0, 3);
    // 2: looping song 0, stopped during second pass
    add(1,0,0,0,0, SIL,0,0,0, 2);
    add(0,1,0,0,1, SIL,1,0,0, 2);
    add(0,0,0,0,1, 6'd5,1,0,0,10); add(0,0,0,0,1, 6'd6,1,0,0,10);
    add(0,0,0,0,1, 6'd7,1,0,0,10); add(0,0,0,0,1, 6'd9,1,0,0,10);
    add(0,0,0,0,1, 6'd5,1,0,0,10); add(0,0,0,0,1, 6'd6,1,0,0,10);
    add(0,0,0,1,0, SIL,0,1,0, 1);  add(0,0,0,0,0, SIL,0,0,1'bx, 2);
    // 3: beep during note at addr 2, replay of that note
    add(1,0,0,0,0, SIL,0,0,0, 2);
    add(0,1,0,0,0, SIL,1,0,0, 2);
    add(0,0,0,0,0, 6'd5,1,0,0,10); add(0,0,0,0,0, 6'd6,1,0,0,10);
    add(0,0,0,0,0, 6'd7,1,0,0,3);
    add(0,0,1,0,0, 6'd7,1,0,0,2);  add(0,0,0,0,0, BP,1,0,0,20);
    add(0,0,0,0,0, 6'd7,1,0,0,10); add(0,0,0,0,0, 6'd9,1,0,0,10);
    add(0,0,0,0,0, SIL,0,1,0, 1);  add(0,0,0,0,0, SIL,0,0,0, 2);
    // 4: stop and beep together mid-song
    add(1,0,0,0,0, SIL,0,0,0, 2);
    add(0,1,0,0,0, SIL,1,0,0, 2);
    add(0,0,0,0,0, 6'd5,1,0,0,10); add(0,0,0,0,0, 6'd6,1,0,0,3);
    add(0,0,1,1,0, SIL,0,1,1'bx,1); add(0,0,0,0,0, SIL,0,0,1'bx,5);
    // 5: play=11 picks song 1, then play=01 restarts song 0
    add(1,0,0,0,0, SIL,0,0,0, 2);
    add(0,3,0,0,0, SIL,1,0,1, 2);
    add(0,0,0,0,0, 6'd40,1,0,1,10); add(0,0,0,0,0, 6'd41,1,0,1,3);
    add(0,1,0,0,0, 6'd41,1,0,0,2);
    add(0,0,0,0,0, 6'd5,1,0,0,10); add(0,0,0,0,0, 6'd6,1,0,0,10);
    add(0,0,0,1,0, SIL,0,1,0, 1);  add(0,0,0,0,0, SIL,0,0,0, 2);
    // 5b: song 1 to its end (length 3)
    add(1,0,0,0,0, SIL,0,0,0, 2);
    add(0,2,0,0,0, SIL,1,0,1, 2);
    add(0,0,0,0,0, 6'd40,1,0,1,10); add(0,0,0,0,0, 6'd41,1,0,1,10);
    add(0,0,0,0,0, 6'd42,1,0,1,10);
    add(0,0,0,0,0, SIL,0,1,1, 1);  add(0,0,0,0,0, SIL,0,0,1, 2);
    // 6a: reset in HOLD, later beep stands alone
    add(1,0,0,0,0, SIL,0,0,0, 2);
    add(0,1,0,0,0, SIL,1,0,0, 2);
    add(0,0,0,0,0, 6'd5,1,0,0,10); add(0,0,0,0,0, 6'd6,1,0,0,4);
    add(1,0,0,0,0, SIL,0,0,0, 1);
    add(0,0,1,0,0, SIL,1,0,0, 2);  add(0,0,0,0,0, BP,1,0,0,20);
    add(0,0,0,0,0, SIL,0,0,0, 3);
    // 6b: reset in BEEP, later beep does not resume the song
    add(0,1,0,0,0, SIL,1,0,0, 2);
    add(0,0,0,0,0, 6'd5,1,0,0,3);
    add(0,0,1,0,0, 6'd5,1,0,0,2);  add(0,0,0,0,0, BP,1,0,0,5);
    add(1,0,0,0,0, SIL,0,0,0, 1);
    add(0,0,1,0,0, SIL,1,0,0, 2);  add(0,0,0,0,0, BP,1,0,0,20);
    add(0,0,0,0,0, SIL,0,0,0, 3);

    foreach (tbl[i]) begin
      for (int k = 0; k < tbl[i].n; k++) begin
        apply(tbl[i].r,
              (k == 0) ? tbl[i].p : 2'b00,
              (k == 0) ? tbl[i].b : 1'b0,
              (k == 0) ? tbl[i].s : 1'b0,
              tbl[i].l, tbl[i].note, tbl[i].busy, tbl[i].done, tbl[i].sel);
      end
    end

    // Play during a stand-alone beep: song 1 starts after the full beep.
    apply(1,0,0,0,0, SIL,0,0,0);
    apply(0,0,1,0,0, SIL,1,0,0);
    apply(0,0,0,0,0, SIL,1,0,0);
    for (int k = 0; k < 3; k++)  apply(0,0,0,0,0, BP,1,0,0);
    apply(0,2,0,0,0, BP,1,0,1);
    for (int k = 0; k < 16; k++) apply(0,0,0,0,0, BP,1,0,1);
    for (int k = 0; k < 10; k++) apply(0,0,0,0,0, 6'd40,1,0,1);
    for (int k = 0; k < 10; k++) apply(0,0,0,0,0, 6'd41,1,0,1);
    for (int k = 0; k < 10; k++) apply(0,0,0,0,0, 6'd42,1,0,1);
    apply(0,0,0,0,0, SIL,0,1,1);
    apply(0,0,0,0,0, SIL,0,0,1);

    // Beep re-triggered mid-beep restarts its slot count.
    apply(1,0,0,0,0, SIL,0,0,0);
    apply(0,0,1,0,0, SIL,1,0,0);
    apply(0,0,0,0,0, SIL,1,0,0);
    for (int k = 0; k < 6; k++)  apply(0,0,0,0,0, BP,1,0,0);
    apply(0,0,1,0,0, BP,1,0,0);
    for (int k = 0; k < 21; k++) apply(0,0,0,0,0, BP,1,0,0);
    apply(0,0,0,0,0, SIL,0,0,0);
    apply(0,0,0,0,0, SIL,0,0,0);

    @(negedge clk);
    rst = 1'b0; play = 2'b00; beep = 1'b0; stop = 1'b0; loop = 1'b0;
    @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain pending=%0d want=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
